// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Optional feature macro: IMEM_BOUNDS_CHECK_EN adds a fault bit to each queue entry.
package imem_fetch_pkg;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam int          FETCH_Q_DEPTH = 2;
    localparam logic [31:0] PC_STEP       = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
`ifdef IMEM_BOUNDS_CHECK_EN
        logic        fault;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_queue.sv
// Two-entry fetch packet FIFO with push, pop and synchronous flush.
// The entry layout depends on IMEM_BOUNDS_CHECK_EN through fetch_entry_t.
module fetch_queue
    import imem_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t mem [FETCH_Q_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'(FETCH_Q_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage array; left unreset because pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush discards everything at once.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage controller: owns the fetch PC, issues one instruction memory
// read per cycle under a 2-slot credit scheme, and hands {pc, instr} to decode.
// Optional feature macro: IMEM_BOUNDS_CHECK_EN turns fetches beyond
// DEPTH_WORDS into faulting NOP packets instead of memory reads.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_fault
);

    localparam logic [32:0] PC_LIMIT = 33'(DEPTH_WORDS) << 2;

    logic [31:0]  fetch_pc;
    logic [31:0]  req_pc;
    logic         inflight;
    logic         flush;
    logic         pop;
    logic         issue;
    logic [2:0]   credit_used;
    logic [2:0]   credit_limit;
    logic [1:0]   q_count;
    logic         q_full;
    logic         q_empty;
    fetch_entry_t q_head;
    fetch_entry_t push_entry;
    logic         unused_sink;

    // Reset and redirect both squash the queue and hide the head from decode.
    assign flush    = rst || redirect_valid;
    assign if_valid = !q_empty && !flush;
    assign pop      = if_valid && if_ready;

    // A slot is free when queued plus outstanding, less what leaves now, is below depth.
    assign credit_used  = {1'b0, q_count} + {2'b00, inflight};
    assign credit_limit = 3'(FETCH_Q_DEPTH) + {2'b00, pop};
    assign issue        = !flush && (credit_used < credit_limit);

    assign imem_addr = fetch_pc;
    assign if_pc     = q_head.pc;
    assign if_instr  = q_head.instr;

`ifdef IMEM_BOUNDS_CHECK_EN
    logic out_of_range;
    logic req_fault;

    assign out_of_range = ({1'b0, fetch_pc} >= PC_LIMIT);
    assign imem_req     = issue && !out_of_range;
    assign push_entry   = '{pc: req_pc, instr: (req_fault ? NOP_INSTR : imem_rdata), fault: req_fault};
    assign if_fault     = if_valid && q_head.fault;
    assign unused_sink  = ^{redirect_pc[1:0], q_full};

    // Remember whether the outstanding slot was a suppressed out-of-range fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_fault <= 1'b0;
        end else if (issue) begin
            req_fault <= out_of_range;
        end
    end
`else
    assign imem_req    = issue;
    assign push_entry  = '{pc: req_pc, instr: imem_rdata};
    assign if_fault    = 1'b0;
    assign unused_sink = ^{redirect_pc[1:0], q_full, PC_LIMIT};
`endif

    // Fetch PC and outstanding-request tracking; clearing inflight on a
    // redirect is what drops the pre-redirect response arriving next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + PC_STEP;
            end
        end
    end

    fetch_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (inflight),
        .push_data (push_entry),
        .pop       (pop),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: a per-cycle vector table covering
// startup, stall, redirects and reset, followed by hand-written streaming and
// (when IMEM_BOUNDS_CHECK_EN is defined) bounds-fault sequences.
module tb_imem_fetch_ctrl;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] LIMIT = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
        logic [31:0] einstr;
    } vec_t;

    vec_t vecs[$];

    imem_fetch_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_fault       (if_fault)
    );

    always #5 clk = ~clk;

    // Synchronous memory model: word i holds 0x1000+i, poison when not read.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (32'h0000_1000 + (imem_addr >> 2)) : 32'hDEAD_BEEF;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                                input logic rdy, input logic ereq, input logic [31:0] eaddr,
                                input logic evalid, input logic [31:0] epc,
                                input logic [31:0] einstr);
        vec_t v;
        v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ereq = ereq;
        v.eaddr = eaddr; v.evalid = evalid; v.epc = epc; v.einstr = einstr;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst            = v.rst;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        if_ready       = v.rdy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          delivered;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b1;

        //              rst rv rpc       rdy req addr      vld pc        instr
        vecs.push_back(mk(1, 0, 32'h0,   1, 0, 32'h0,   0, 32'h0,  32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 0, 32'h0,   0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h0,   0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h4,   0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h8,   1, 32'h0,  32'h1000));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'hC,   1, 32'h4,  32'h1001));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h8,  32'h1002));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h8,  32'h1002));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h8,  32'h1002));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h8,  32'h1002));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h10,  1, 32'h8,  32'h1002));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h14,  1, 32'hC,  32'h1003));
        vecs.push_back(mk(0, 1, 32'h40,  1, 0, 32'h0,   0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h40,  0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h44,  0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h48,  1, 32'h40, 32'h1010));
        vecs.push_back(mk(0, 1, 32'h43,  1, 0, 32'h0,   0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h40,  0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h44,  0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h48,  1, 32'h40, 32'h1010));
        vecs.push_back(mk(0, 1, 32'h80,  1, 0, 32'h0,   0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 1, 32'hC0,  1, 0, 32'h0,   0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'hC0,  0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'hC4,  0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'hC8,  1, 32'hC0, 32'h1030));
        vecs.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h0,   0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h4,   0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h8,   1, 32'h0,  32'h1000));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'hC,   1, 32'h4,  32'h1001));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
            #4;
            checkOutput($sformatf("v%0d.imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].ereq});
            if (vecs[i].ereq) begin
                checkOutput($sformatf("v%0d.imem_addr", i), imem_addr, vecs[i].eaddr);
            end
            checkOutput($sformatf("v%0d.if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].evalid});
            if (vecs[i].evalid) begin
                checkOutput($sformatf("v%0d.if_pc", i), if_pc, vecs[i].epc);
                checkOutput($sformatf("v%0d.if_instr", i), if_instr, vecs[i].einstr);
                checkOutput($sformatf("v%0d.if_fault", i), {31'b0, if_fault}, 32'h0);
            end
        end

        // Streaming with a periodic stall: every accepted packet must follow the last.
        exp_pc    = 32'h8;
        delivered = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if_ready = (i % 3 != 2);
            #4;
            if (if_valid) begin
                checkOutput($sformatf("stream%0d.pc", i), if_pc, exp_pc);
                checkOutput($sformatf("stream%0d.instr", i), if_instr, 32'h1000 + (exp_pc >> 2));
                if (if_ready) begin
                    exp_pc = exp_pc + 32'd4;
                    delivered++;
                end
            end
        end
        checkOutput("stream.delivered", delivered, 14);

`ifdef IMEM_BOUNDS_CHECK_EN
        begin
            logic [31:0] bpc[3];
            logic [31:0] binstr[3];
            logic        bfault[3];
            int          got;
            bpc[0] = LIMIT - 32'd8; binstr[0] = 32'h1000 + ((LIMIT - 32'd8) >> 2); bfault[0] = 1'b0;
            bpc[1] = LIMIT - 32'd4; binstr[1] = 32'h1000 + ((LIMIT - 32'd4) >> 2); bfault[1] = 1'b0;
            bpc[2] = LIMIT;         binstr[2] = 32'h0000_0013;                     bfault[2] = 1'b1;

            @(posedge clk);
            #1;
            if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = LIMIT - 32'd8;
            @(posedge clk);
            #1;
            redirect_valid = 1'b0;
            got = 0;
            for (int c = 0; c < 12 && got < 3; c++) begin
                #4;
                if (imem_req) begin
                    checkOutput("bounds.req_in_range", {31'b0, (imem_addr < LIMIT)}, 32'h1);
                end
                if (if_valid) begin
                    checkOutput($sformatf("bounds%0d.pc", got), if_pc, bpc[got]);
                    checkOutput($sformatf("bounds%0d.instr", got), if_instr, binstr[got]);
                    checkOutput($sformatf("bounds%0d.fault", got), {31'b0, if_fault}, {31'b0, bfault[got]});
                    got++;
                end
                @(posedge clk);
                #1;
            end
            checkOutput("bounds.packets", got, 3);

            redirect_valid = 1'b1; redirect_pc = 32'h0;
            @(posedge clk);
            #1;
            redirect_valid = 1'b0;
            got = 0;
            for (int c = 0; c < 8 && got == 0; c++) begin
                #4;
                if (if_valid) begin
                    checkOutput("bounds.back.pc", if_pc, 32'h0);
                    checkOutput("bounds.back.fault", {31'b0, if_fault}, 32'h0);
                    got = 1;
                end
                @(posedge clk);
                #1;
            end
            checkOutput("bounds.back.seen", got, 1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Fetch-stage controller that sequences the word-addressed instruction memory for the pipelined core.
- Owns the fetch PC, issues one read per cycle, and buffers returned words in a 2-entry queue.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Handles decode back-pressure (stall) and branch/jump redirects (flush), including discarding responses already in flight.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH_WORDS, 256, instruction memory size in 32-bit words (used only by the optional bounds check)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  32  redirect target, byte address
imem_req  out  1  memory read strobe
imem_addr  out  32  byte address; memory indexes addr>>2
imem_rdata  in  32  read data, valid the cycle after imem_req
if_valid  out  1  fetch packet valid to decode
if_ready  in  1  decode accepts packet (low = stall)
if_pc  out  32  PC of packet
if_instr  out  32  instruction word of packet
if_fault  out  1  out-of-range fetch (optional feature; tied 0 otherwise)

Behaviour:
- Reset state (clock edge with rst=1): fetch_pc=RESET_PC; FIFO empty; inflight=0; if_valid=0; imem_req=0; if_fault=0.
- rst has priority over redirect_valid.
- A response arriving after a reset edge is ignored: capture requires inflight=1.
- Issue rule: imem_req=1 when rst=0, redirect_valid=0, and (count + inflight - pop) < 2, where pop = if_valid & if_ready.
- On issue: imem_addr=fetch_pc and fetch_pc <= fetch_pc+4. The add wraps modulo 2^32.
- Response: when inflight=1, imem_rdata is pushed as {pc_of_request, imem_rdata} at the end of the response cycle. There is no bypass.
- Latency: request in cycle T, if_valid at T+2 (FIFO empty, if_ready=1).
- Throughput: 1 instruction/cycle while if_ready is held high.
- Handshake:
  - if_valid = FIFO non-empty.
  - if_pc/if_instr come from the FIFO head and are don't-care while if_valid=0.
  - Head holds stable while if_valid & !if_ready.
  - Pop on if_valid & if_ready.
  - Push and pop in the same cycle are legal with count unchanged.
- Full: count=2 forces imem_req=0. No entry is overwritten and no PC is skipped.
- Redirect (cycle T, redirect_valid=1, rst=0):
  - if_valid forced 0 and imem_req=0 in T.
  - At end of T: FIFO cleared, fetch_pc <= {redirect_pc[31:2],2'b00}, and any in-flight response is marked to drop.
  - Response arriving in T+1 from a pre-redirect request is discarded.
  - Request for the target issues in T+1; its packet is valid in T+3.
- Back-to-back redirects: the last one wins.
- Redirect while stalled: the stalled packet is discarded.

Optional Feature:
IMEM_BOUNDS_CHECK_EN
- Defined:
  - A fetch with fetch_pc >= DEPTH_WORDS*4 keeps its issue slot and timing but drives imem_req=0.
  - Next cycle it pushes an entry with instr=32'h0000_0013 (NOP) and fault=1.
  - if_fault reflects the head entry's fault bit.
  - fetch_pc still increments.
- Undefined: no range check; if_fault tied 0; the FIFO entry has no fault bit.

Decomposition:
- Package imem_fetch_pkg:
  - NOP_INSTR = 32'h0000_0013
  - FETCH_Q_DEPTH = 2
  - PC_STEP = 4
  - typedef fetch_entry_t {pc[31:0], instr[31:0], fault}
- Sub-module fetch_queue:
  - 2-entry FIFO with push, pop and synchronous flush.
  - Exposes count, head and full.
- Top-level holds fetch_pc, inflight/drop flags, and the issue/credit logic.

Test Plan:
1. Release rst; memory word i = 0x1000+i; if_ready=1 -> imem_req at R, if_valid at R+2 with pc=0x0/instr=0x1000, then pc 0x4, 0x8, 0xC on consecutive cycles.
2. Stall while pc=0x8 at head: if_ready=0 for 4 cycles -> pc=0x8/instr=0x1002 held; imem_req drops once count+inflight=2. On release: sequence 0x8, 0xC, 0x10 with no skip or duplicate.
3. redirect_valid with redirect_pc=0x40 while a request for 0x10 is in flight -> if_valid=0 in T; no 0x10/0x14 delivered; next valid pc=0x40 at T+3.
4. redirect_pc=0x43 -> imem_addr=0x40 at T+1 and delivered if_pc=0x40. Two redirects in T (0x80) and T+1 (0xC0) -> first packet pc=0xC0.
5. rst pulsed for one cycle while FIFO full and a request is in flight -> if_valid=0 the cycle after reset; stale response ignored; restart at RESET_PC with a 2-cycle latency.
6. With IMEM_BOUNDS_CHECK_EN and DEPTH_WORDS=4, run to pc 0x10 -> imem_req=0 for that slot; packet pc=0x10, instr=0x13, if_fault=1. Redirect to 0x0 -> if_fault=0.
